gf180mcu_fd_sc_mcu9t5v0__invz_busarb: RTL

GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__invz_busarb

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__busarb_pkg.sv | 15 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__rr_pick.sv | 32 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__invz_busarb.sv | 118 +++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__busarb_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// State encoding plus default parameter constants.
package gf180mcu_fd_sc_mcu9t5v0__busarb_pkg;

   localparam int N_DEF        = 4;
   localparam int TURN_CYC_DEF = 1;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_pick.sv
// Combinational round-robin picker: first set request
// at or after the start index, wrapping modulo N.
module gf180mcu_fd_sc_mcu9t5v0__rr_pick
   import gf180mcu_fd_sc_mcu9t5v0__busarb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         valid,
   output logic [W-1:0] idx
);

   int j;

   // Scan from the far end back to start so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(start) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            valid = 1'b1;
            idx   = W'(j);
         end
      end
   end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_busarb.sv
// Arbiter for N tri-state inverters sharing one net with keeper.
// Optional forced release: GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu9t5v0__invz_busarb
   import gf180mcu_fd_sc_mcu9t5v0__busarb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int TURN_CYC = TURN_CYC_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   localparam int W       = (N > 1) ? $clog2(N) : 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [N-1:0] REQ,
   output logic [N-1:0] EN,
   output logic         KEEP,
   output logic [W-1:0] OWNER
);

   localparam logic [N-1:0] ONE     = N'(1);
   localparam logic [2:0]   TC_LAST = 3'(TURN_CYC - 1);

   if (TURN_CYC < 1 || TURN_CYC > 7) begin : g_bad_turn
      $error("TURN_CYC must be within 1..7");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD must be within 2..255");
   end

   state_t         state;
   logic [N-1:0]   en_q;
   logic           keep_q;
   logic [W-1:0]   owner_q;
   logic [2:0]     turn_cnt;
   logic [W-1:0]   start;
   logic           pick_valid;
   logic [W-1:0]   pick_idx;
   logic           grant_ok;
   logic           release_bus;

   // Search begins one past the current/last owner.
   always_comb begin
      start = (owner_q == W'(N - 1)) ? '0 : owner_q + W'(1);
   end

   gf180mcu_fd_sc_mcu9t5v0__rr_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .req   (REQ),
      .start (start),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign grant_ok = pick_valid &&
                     (state == ST_IDLE ||
                      (state == ST_TURN && turn_cnt == TC_LAST));

`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       others;

   assign others      = |(REQ & ~(ONE << owner_q));
   assign release_bus = !REQ[owner_q] ||
                        (hold_cnt >= 8'(MAX_HOLD) && others);
`else
   assign release_bus = !REQ[owner_q];
`endif

   // Bus ownership FSM; EN/KEEP/OWNER are all registered here.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         en_q     <= '0;
         keep_q   <= 1'b1;
         owner_q  <= W'(N - 1);
         turn_cnt <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB_TIMEOUT_EN
         hold_cnt <= '0;
`endif
      end else if (grant_ok) begin
         state   <= ST_DRIVE;
         en_q    <= ONE << pick_idx;
         keep_q  <= 1'b0;
         owner_q <= pick_idx;
`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB_TIMEOUT_EN
         hold_cnt <= 8'd1;
`endif
      end else begin
         unique case (state)
            ST_IDLE: ;
            ST_DRIVE: begin
               if (release_bus) begin
                  state    <= ST_TURN;
                  en_q     <= '0;
                  keep_q   <= 1'b1;
                  turn_cnt <= '0;
               end
`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_BUSARB_TIMEOUT_EN
               else if (hold_cnt < 8'(MAX_HOLD)) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
`endif
            end
            ST_TURN: begin
               if (turn_cnt == TC_LAST) state <= ST_IDLE;
               else turn_cnt <= turn_cnt + 3'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign EN    = en_q;
   assign KEEP  = keep_q;
   assign OWNER = owner_q;

endmodule
